uart_rx_frame_ctrl: RTL and testbench



---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_frame_fifo.sv | 74 +++++++
 rtl/uart_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive frame controller: FSM states,
// FIFO entry layout and the overflow terminator entry.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Entry = {ovf, frame_err, byte_err, last, data[7:0]}
    localparam int ENTRY_W  = 12;
    localparam int DATA_LSB = 0;
    localparam int LAST_BIT = 8;
    localparam int BERR_BIT = 9;
    localparam int FERR_BIT = 10;
    localparam int OVF_BIT  = 11;

    // Marks a frame that lost bytes: every status bit set, data zero.
    localparam logic [ENTRY_W-1:0] TERM_ENTRY = 12'hF00;

    function automatic logic [ENTRY_W-1:0] mk_entry(
        input logic       ovf,
        input logic       frame_err,
        input logic       byte_err,
        input logic       last,
        input logic [7:0] data
    );
        return {ovf, frame_err, byte_err, last, data};
    endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Synchronous FIFO with a registered head entry that reads as zero when empty.
module uart_frame_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [WIDTH-1:0]           o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rp_nxt;

    // Full is judged on current occupancy only, so a same-cycle pop never
    // rescues a push into a full FIFO.
    assign o_full   = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty  = (r_cnt == '0);
    assign w_push   = i_push & ~o_full;
    assign w_pop    = i_pop & ~o_empty;
    assign w_rp_nxt = r_rp + AW'(1);
    assign o_level  = r_cnt;
    assign o_head   = r_head;

    // Storage array; no reset needed, occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= w_rp_nxt;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Head register tracks the oldest entry; bypasses the array when the
    // FIFO is (or becomes) empty so the new entry shows the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_pop && r_cnt == (AW+1)'(1)) begin
            r_head <= w_push ? i_din : '0;
        end else if (w_pop) begin
            r_head <= r_mem[w_rp_nxt];
        end else if (w_push && o_empty) begin
            r_head <= i_din;
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level receive controller: delimits frames by inter-character
// silence, stages the newest byte until its fate (mid/last) is known,
// and queues bytes with per-byte and per-frame status.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int GAP_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_en,
    input  logic [GAP_W-1:0]          gap_cycles,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    input  logic                      in_framing_err,
    input  logic                      in_parity_err,
    output logic [7:0]                m_data,
    output logic                      m_last,
    output logic                      m_byte_err,
    output logic                      m_frame_err,
    output logic                      m_ovf,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      frame_done,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic [15:0]               err_count,
    output logic [15:0]               ovf_count
);
    state_t             r_state, w_nstate;
    logic [7:0]         r_stage_data;
    logic               r_stage_berr;
    logic               r_acc;
    logic [GAP_W-1:0]   r_timer;
    logic               r_pend;
    logic [15:0]        r_err_cnt;
    logic [15:0]        r_ovf_cnt;
    logic               r_fd;

    logic               w_acc;
    logic [GAP_W-1:0]   w_gap_m1;
    logic               w_tmo;
    logic               w_ferr;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_head;
    logic               w_push;
    logic [ENTRY_W-1:0] w_din;
    logic               w_ld_stage;
    logic               w_clr_acc;
    logic               w_acc_set;
    logic               w_tmr_clr;
    logic               w_tmr_inc;
    logic               w_pend_nxt;
    logic               w_err_inc;
    logic               w_ovf_inc;

    assign w_acc    = in_valid & rx_en;
    // gap_cycles of 0 behaves as 1
    assign w_gap_m1 = (gap_cycles == '0) ? '0 : gap_cycles - GAP_W'(1);
    assign w_tmo    = (r_timer == w_gap_m1);
    assign w_ferr   = r_acc | r_stage_berr;

    uart_frame_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (m_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level),
        .o_head  (w_head)
    );

    assign m_data      = w_head[DATA_LSB +: 8];
    assign m_last      = w_head[LAST_BIT];
    assign m_byte_err  = w_head[BERR_BIT];
    assign m_frame_err = w_head[FERR_BIT];
    assign m_ovf       = w_head[OVF_BIT];
    assign m_valid     = ~w_empty;
    assign frame_done  = r_fd;
    assign busy        = (r_state != S_IDLE);
    assign err_count   = r_err_cnt;
    assign ovf_count   = r_ovf_cnt;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nstate;
    end

    // Next state and datapath controls. An accepted byte takes priority
    // over gap expiry in the same cycle.
    always_comb begin
        w_nstate   = r_state;
        w_push     = 1'b0;
        w_din      = '0;
        w_ld_stage = 1'b0;
        w_clr_acc  = 1'b0;
        w_acc_set  = 1'b0;
        w_tmr_clr  = 1'b0;
        w_tmr_inc  = (r_state != S_IDLE);
        w_pend_nxt = r_pend;
        w_err_inc  = 1'b0;
        w_ovf_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_ld_stage = 1'b1;
                    w_clr_acc  = 1'b1;
                    w_tmr_clr  = 1'b1;
                    w_nstate   = S_RECV;
                end
            end
            S_RECV: begin
                if (w_acc) begin
                    w_tmr_clr = 1'b1;
                    if (!w_full) begin
                        w_push     = 1'b1;
                        w_din      = mk_entry(1'b0, 1'b0, r_stage_berr, 1'b0, r_stage_data);
                        w_ld_stage = 1'b1;
                        w_acc_set  = 1'b1;
                    end else begin
                        w_ovf_inc = 1'b1;
                        w_nstate  = S_DROP;
                    end
                end else if (w_tmo) begin
                    if (!w_full) begin
                        w_push    = 1'b1;
                        w_din     = mk_entry(1'b0, w_ferr, r_stage_berr, 1'b1, r_stage_data);
                        w_err_inc = w_ferr;
                        w_nstate  = S_IDLE;
                    end else begin
                        // Closing byte lost: terminate as a dropped frame
                        // as soon as space appears.
                        w_ovf_inc  = 1'b1;
                        w_pend_nxt = 1'b1;
                        w_tmr_inc  = 1'b0;
                        w_nstate   = S_DROP;
                    end
                end
            end
            S_DROP: begin
                if (r_pend || (!w_acc && w_tmo)) begin
                    w_tmr_inc = 1'b0;
                    if (!w_full) begin
                        w_push     = 1'b1;
                        w_din      = TERM_ENTRY;
                        w_err_inc  = 1'b1;
                        w_pend_nxt = 1'b0;
                        w_nstate   = S_IDLE;
                    end else begin
                        w_pend_nxt = 1'b1;
                    end
                end else if (w_acc) begin
                    w_tmr_clr = 1'b1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // Staging byte, frame error accumulator, gap timer and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_data <= '0;
            r_stage_berr <= 1'b0;
            r_acc        <= 1'b0;
            r_timer      <= '0;
            r_pend       <= 1'b0;
        end else begin
            if (w_ld_stage) begin
                r_stage_data <= in_data;
                r_stage_berr <= in_framing_err | in_parity_err;
            end
            if (w_clr_acc)      r_acc <= 1'b0;
            else if (w_acc_set) r_acc <= r_acc | r_stage_berr;
            if (w_tmr_clr)      r_timer <= '0;
            else if (w_tmr_inc) r_timer <= r_timer + GAP_W'(1);
            r_pend <= w_pend_nxt;
        end
    end

    // Frame-done pulse and saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fd      <= 1'b0;
            r_err_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            r_fd <= w_push & w_din[LAST_BIT];
            if (w_err_inc && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            if (w_ovf_inc && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frame-level model with a per-cycle compare,
// plus literal expectations on the consumed byte stream and frame timing.
module tb_uart_rx_frame_ctrl;
    localparam int DEPTH = 4;
    localparam int GAP_W = 24;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_en = 1'b0;
    logic [GAP_W-1:0] gap_cycles = 24'd10;
    logic [7:0]       in_data = 8'h00;
    logic             in_valid = 1'b0;
    logic             in_framing_err = 1'b0;
    logic             in_parity_err = 1'b0;
    logic             m_ready = 1'b0;
    logic [7:0]       m_data;
    logic             m_last, m_byte_err, m_frame_err, m_ovf, m_valid;
    logic             frame_done, busy;
    logic [LW-1:0]    level;
    logic [15:0]      err_count, ovf_count;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx_en          (rx_en),
        .gap_cycles     (gap_cycles),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_framing_err (in_framing_err),
        .in_parity_err  (in_parity_err),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_byte_err     (m_byte_err),
        .m_frame_err    (m_frame_err),
        .m_ovf          (m_ovf),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .frame_done     (frame_done),
        .busy           (busy),
        .level          (level),
        .err_count      (err_count),
        .ovf_count      (ovf_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int strobe_cyc = 0;
    int fd_cyc = 0;
    int fd_n = 0;
    logic [11:0] got[$];
    logic [11:0] ex[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // Queue of entries the FIFO must hold; one open frame with a held-back
    // newest byte; silence measured in edges since the last accepted byte.
    logic [11:0] mq[$];
    bit          mopen = 0, mdrop = 0, mpend = 0, mfd = 0;
    logic [7:0]  ms_d = 8'h00;
    bit          ms_be = 0, macc = 0;
    int          msince = 0, merr = 0, movf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mopen = 0; mdrop = 0; mpend = 0; mfd = 0;
            macc = 0; msince = 0; merr = 0; movf = 0;
        end else begin
            bit acc, full, do_push, silent;
            logic [11:0] pe;
            int gm;
            gm      = (gap_cycles == 0) ? 1 : int'(gap_cycles);
            acc     = in_valid && rx_en;
            full    = (mq.size() == DEPTH);
            silent  = !acc && (msince + 1 == gm);
            do_push = 0;
            pe      = 12'h000;
            mfd     = 0;
            if (!mopen) begin
                if (acc) begin
                    ms_d = in_data; ms_be = in_framing_err | in_parity_err;
                    macc = 0; mopen = 1; mdrop = 0; mpend = 0; msince = 0;
                end
            end else if (!mdrop) begin
                if (acc) begin
                    msince = 0;
                    if (!full) begin
                        do_push = 1; pe = {3'b000, ms_be, 1'b0, ms_d} >> 0;
                        pe = {1'b0, 1'b0, ms_be, 1'b0, ms_d};
                        macc = macc | ms_be;
                        ms_d = in_data; ms_be = in_framing_err | in_parity_err;
                    end else begin
                        movf++; mdrop = 1;
                    end
                end else if (silent) begin
                    if (!full) begin
                        do_push = 1;
                        pe = {1'b0, macc | ms_be, ms_be, 1'b1, ms_d};
                        if (macc | ms_be) merr++;
                        mopen = 0;
                    end else begin
                        movf++; mdrop = 1; mpend = 1;
                    end
                end else msince++;
            end else begin
                if (mpend || silent) begin
                    if (!full) begin
                        do_push = 1; pe = 12'hF00; merr++;
                        mopen = 0; mdrop = 0; mpend = 0;
                    end else mpend = 1;
                end else if (acc) msince = 0;
                else msince++;
            end
            if (m_ready && mq.size() > 0) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back(pe);
                mfd = pe[8];
            end
        end
    end

    // Per-cycle compare against the model, plus capture of consumed entries.
    always @(negedge clk) begin
        logic [11:0] h;
        h = (mq.size() != 0) ? mq[0] : 12'h000;
        chk("head", {m_valid, m_ovf, m_frame_err, m_byte_err, m_last, m_data},
                    {mq.size() != 0, h});
        chk("level", 64'(level), 64'(mq.size()));
        chk("busy_fd", {busy, frame_done}, {mopen, mfd});
        chk("counters", {err_count, ovf_count}, {16'(merr), 16'(movf)});
        if (rst_n && m_valid && m_ready)
            got.push_back({m_ovf, m_frame_err, m_byte_err, m_last, m_data});
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Called 2 time units after a rising edge; the byte is accepted on the next edge.
    task automatic strobe(input logic [7:0] d, input bit pe);
        in_data = d;
        in_parity_err = pe;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        strobe_cyc = cyc;
        in_valid = 1'b0;
        in_parity_err = 1'b0;
    endtask

    task automatic expect_got(input string name);
        chk({name, "_count"}, 64'(got.size()), 64'(ex.size()));
        for (int i = 0; i < ex.size(); i++)
            if (i < got.size()) chk(name, 64'(got[i]), 64'(ex[i]));
    endtask

    initial begin
        rx_en = 1'b1;
        m_ready = 1'b1;
        idle(3);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_valid_busy", {m_valid, busy}, 2'b00);
        rst_n = 1'b1;
        idle(2);

        // Clean 3-byte frame
        got.delete(); fd_n = 0;
        strobe(8'h01, 0); idle(4);
        strobe(8'h02, 0); idle(4);
        strobe(8'h03, 0); idle(15);
        chk("t1_fd_delay", 64'(fd_cyc - strobe_cyc), 64'd10);
        chk("t1_fd_n", 64'(fd_n), 64'd1);
        ex.delete(); ex.push_back(12'h001); ex.push_back(12'h002); ex.push_back(12'h103);
        expect_got("t1_stream");
        chk("t1_err_count", 64'(err_count), 64'd0);

        // Parity error on middle byte
        got.delete();
        strobe(8'h01, 0); idle(4);
        strobe(8'h02, 1); idle(4);
        strobe(8'h03, 0); idle(15);
        ex.delete(); ex.push_back(12'h001); ex.push_back(12'h202); ex.push_back(12'h503);
        expect_got("t2_stream");
        chk("t2_err_count", 64'(err_count), 64'd1);

        // Overflow: consumer stalled, 7 bytes into a 4-deep FIFO
        got.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            strobe(8'h10 + 8'(i), 0); idle(1);
        end
        idle(2);
        chk("t3_level_full", 64'(level), 64'd4);
        chk("t3_ovf_count", 64'(ovf_count), 64'd1);
        chk("t3_busy_drop", 64'(busy), 64'd1);
        idle(12);
        chk("t3_still_waiting", {busy, 3'(level)}, {1'b1, 3'd4});
        m_ready = 1'b1;
        idle(10);
        ex.delete();
        ex.push_back(12'h010); ex.push_back(12'h011); ex.push_back(12'h012);
        ex.push_back(12'h013); ex.push_back(12'hF00);
        expect_got("t3_stream");
        chk("t3_err_count", 64'(err_count), 64'd2);
        chk("t3_idle", 64'(busy), 64'd0);

        // Byte lands exactly on the expiry edge: frame extends
        got.delete(); fd_n = 0;
        strobe(8'h31, 0); idle(9);
        strobe(8'h32, 0); idle(4);
        strobe(8'h33, 0); idle(15);
        chk("t4_fd_n", 64'(fd_n), 64'd1);
        chk("t4_fd_delay", 64'(fd_cyc - strobe_cyc), 64'd10);
        ex.delete(); ex.push_back(12'h031); ex.push_back(12'h032); ex.push_back(12'h133);
        expect_got("t4_stream");

        // gap_cycles = 0 behaves as 1
        got.delete(); fd_n = 0;
        gap_cycles = 24'd0;
        strobe(8'hA5, 0); idle(3);
        chk("t5_fd_delay", 64'(fd_cyc - strobe_cyc), 64'd1);
        chk("t5_fd_n", 64'(fd_n), 64'd1);
        ex.delete(); ex.push_back(12'h1A5);
        expect_got("t5_stream");

        // Reset mid-frame with 3 entries queued
        gap_cycles = 24'd10;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(8'h40 + 8'(i), 0); idle(1);
        end
        chk("t6_level_pre", 64'(level), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_async_clear", {m_valid, busy, 3'(level)}, 5'b0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        m_ready = 1'b1;
        got.delete();
        strobe(8'h55, 0); idle(13);
        ex.delete(); ex.push_back(12'h155);
        expect_got("t6_stream");
        chk("t6_counters", {err_count, ovf_count}, 32'd0);
        chk("t6_level_end", 64'(level), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
